control_ajustes: RTL and testbench
==================================

CONTROL_AJUSTES -- requirements
Module: control_ajustes

Interface
REQ-001 Parameter HOLD_CYCLES, default 50000000: cycles a step button is held before auto-repeat starts.
REQ-002 Parameter REPEAT_CYCLES, default 10000000: cycles between auto-repeat steps.
REQ-003 Parameter TRIG_STEP, default 4: trigger-level increment per step.
REQ-004 Port clk, input, 1: single system clock; all state on rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-low reset.
REQ-006 Port btn_up, input, 1: debounced, clk-synchronous level; 1 = pressed.
REQ-007 Port btn_down, input, 1: debounced, clk-synchronous level; 1 = pressed.
REQ-008 Port btn_sel, input, 1: debounced, clk-synchronous level; 1 = pressed.
REQ-009 Port sel, output, 2: active setting; 0 = volt/div, 1 = time/div, 2 = trigger level; 3 never driven.
REQ-010 Port volt_div, output, 3: vertical scale index, 0..7.
REQ-011 Port time_div, output, 4: horizontal scale index, 0..11.
REQ-012 Port trig_level, output, 8: trigger level, 0..255.
REQ-013 Port cfg_stb, output, 1: one-cycle pulse in the cycle after any of sel/volt_div/time_div/trig_level changes.

Function
REQ-014 Rising edge of btn_sel (0 in previous cycle, 1 now) SHALL advance sel 0->1->2->0 when step FSM is IDLE; otherwise the edge is discarded.
REQ-015 Step FSM states SHALL be IDLE, PRESS, HOLD, REPEAT, LOCK.
REQ-016 IDLE: exactly one of btn_up/btn_down high -> apply one step in direction, go PRESS; both high -> LOCK; none -> stay.
REQ-017 PRESS (one cycle): direction button still held -> HOLD with hold counter cleared; else IDLE.
REQ-018 HOLD: counter increments each cycle; direction button released -> IDLE; counter reaches HOLD_CYCLES-1 -> apply one step, go REPEAT with counter cleared.
REQ-019 REPEAT: counter increments; reaches REPEAT_CYCLES-1 -> apply one step, counter cleared, stay; direction button released -> IDLE.
REQ-020 In HOLD/REPEAT, opposite button also high -> LOCK, no step that cycle.
REQ-021 LOCK: no steps; exit to IDLE only when btn_up and btn_down are both 0.
REQ-022 Direction SHALL be latched on IDLE exit; a changed button in PRESS/HOLD/REPEAT never reverses direction.
REQ-023 Step targets setting selected by sel at step time: volt_div +/-1, time_div +/-1, trig_level +/-TRIG_STEP.
REQ-024 Steps SHALL saturate: volt_div in 0..7, time_div in 0..11, trig_level clamps to 0 or 255 (e.g. 254+4 -> 255, 2-4 -> 0); no wrap-around.
REQ-025 A step producing no value change (already saturated) SHALL NOT pulse cfg_stb.
REQ-026 Step applied in cycle N SHALL be visible on outputs at edge N+1; cfg_stb high during cycle N+2 only.
REQ-027 Counters SHALL be wide enough for max(HOLD_CYCLES, REPEAT_CYCLES) without overflow.

Reset
REQ-028 reset low SHALL immediately force: FSM IDLE, counters 0, sel 0, volt_div 3, time_div 5, trig_level 128, cfg_stb 0, btn_sel edge register 0.
REQ-029 reset asserted mid-HOLD/REPEAT SHALL abort the step in progress; after release, a still-held button is treated as a new press from IDLE.
REQ-030 Outputs after reset release SHALL hold reset values until first step or sel edge.

Verification (HOLD_CYCLES=8, REPEAT_CYCLES=4)
REQ-031 Reset, sel=0, btn_up pulsed 3 cycles -> volt_div 3->4, exactly one cfg_stb, no auto-repeat.
REQ-032 sel=2, btn_up held 20 cycles -> trig_level 128->132 at press, 136 after 8 more cycles, then +4 every 4 cycles; cfg_stb per step.
REQ-033 sel=1, time_div=11, btn_up press -> time_div stays 11, cfg_stb stays 0; btn_down press -> 10, one cfg_stb.
REQ-034 btn_up and btn_down rise same cycle -> no change, FSM LOCK; release one only -> still no steps; release both -> IDLE.
REQ-035 btn_sel pressed 3 times with gaps -> sel 0->1->2->0, three cfg_stb; btn_sel edge during HOLD -> sel unchanged.
REQ-036 reset asserted while btn_down held in REPEAT -> outputs return to 3/5/128 asynchronously; after release with btn_down still high -> one immediate step, auto-repeat after 8 further cycles.

Source files
------------

// File: rtl/control_ajustes.sv
// control_ajustes: oscilloscope settings control (volt/div, time/div, trigger).
// Ports: clk, reset (async, active-low), btn_up/btn_down/btn_sel (debounced
// levels), sel, volt_div, time_div, trig_level (current settings), cfg_stb
// (one-cycle pulse in the cycle after any setting changes).
module control_ajustes #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int TRIG_STEP     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_sel,
    output logic [1:0] sel,
    output logic [2:0] volt_div,
    output logic [3:0] time_div,
    output logic [7:0] trig_level,
    output logic       cfg_stb
);

    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ?
                          HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS,
        HOLD,
        REPEAT,
        LOCK
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          dir_up;
    logic          btn_sel_q;
    logic          chg;

    logic          held;
    logic          opp;
    logic          step;
    logic          step_up;
    logic          sel_edge;
    logic [8:0]    trig_sum;
    logic [1:0]    nxt_sel;
    logic [2:0]    nxt_volt;
    logic [3:0]    nxt_time;
    logic [7:0]    nxt_trig;
    logic          changed;

    // Direction is latched on IDLE exit; later button changes only
    // matter as "released" or "opposite pressed".
    assign held     = dir_up ? btn_up : btn_down;
    assign opp      = dir_up ? btn_down : btn_up;
    assign sel_edge = btn_sel && !btn_sel_q && (state == IDLE);
    assign trig_sum = {1'b0, trig_level} + 9'(TRIG_STEP);

    always_comb begin
        step    = 1'b0;
        step_up = dir_up;
        case (state)
            IDLE: begin
                step    = btn_up ^ btn_down;
                step_up = btn_up;
            end
            HOLD:
                step = held && !opp && (cnt == CW'(HOLD_CYCLES - 1));
            REPEAT:
                step = held && !opp && (cnt == CW'(REPEAT_CYCLES - 1));
            default: step = 1'b0;
        endcase
    end

    // Step acts on the setting selected now; all steps saturate.
    always_comb begin
        nxt_sel  = sel;
        nxt_volt = volt_div;
        nxt_time = time_div;
        nxt_trig = trig_level;
        if (step) begin
            case (sel)
                2'd0: begin
                    if (step_up && volt_div != 3'd7)
                        nxt_volt = volt_div + 3'd1;
                    else if (!step_up && volt_div != 3'd0)
                        nxt_volt = volt_div - 3'd1;
                end
                2'd1: begin
                    if (step_up && time_div < 4'd11)
                        nxt_time = time_div + 4'd1;
                    else if (!step_up && time_div != 4'd0)
                        nxt_time = time_div - 4'd1;
                end
                2'd2: begin
                    if (step_up)
                        nxt_trig = trig_sum[8] ? 8'd255 : trig_sum[7:0];
                    else if ({1'b0, trig_level} < 9'(TRIG_STEP))
                        nxt_trig = 8'd0;
                    else
                        nxt_trig = trig_level - 8'(TRIG_STEP);
                end
                default: nxt_sel = sel;
            endcase
        end
        if (sel_edge)
            nxt_sel = (sel == 2'd2) ? 2'd0 : sel + 2'd1;
    end

    assign changed = {nxt_sel, nxt_volt, nxt_time, nxt_trig} !=
                     {sel, volt_div, time_div, trig_level};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            dir_up     <= 1'b0;
            btn_sel_q  <= 1'b0;
            chg        <= 1'b0;
            cfg_stb    <= 1'b0;
            sel        <= 2'd0;
            volt_div   <= 3'd3;
            time_div   <= 4'd5;
            trig_level <= 8'd128;
        end else begin
            btn_sel_q  <= btn_sel;
            sel        <= nxt_sel;
            volt_div   <= nxt_volt;
            time_div   <= nxt_time;
            trig_level <= nxt_trig;
            // Two stages: value lands at N+1, strobe during N+2.
            chg        <= changed;
            cfg_stb    <= chg;
            case (state)
                IDLE: begin
                    if (btn_up && btn_down) begin
                        state <= LOCK;
                    end else if (btn_up ^ btn_down) begin
                        dir_up <= btn_up;
                        state  <= PRESS;
                    end
                end
                PRESS: begin
                    if (held) begin
                        state <= HOLD;
                        cnt   <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!held)
                        state <= IDLE;
                    else if (opp)
                        state <= LOCK;
                    else if (cnt == CW'(HOLD_CYCLES - 1)) begin
                        state <= REPEAT;
                        cnt   <= '0;
                    end else
                        cnt <= cnt + 1'b1;
                end
                REPEAT: begin
                    if (!held)
                        state <= IDLE;
                    else if (opp)
                        state <= LOCK;
                    else if (cnt == CW'(REPEAT_CYCLES - 1))
                        cnt <= '0;
                    else
                        cnt <= cnt + 1'b1;
                end
                LOCK: begin
                    if (!btn_up && !btn_down)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_control_ajustes.sv
// tb_control_ajustes: directed bench for control_ajustes
// with HOLD_CYCLES=8, REPEAT_CYCLES=4, TRIG_STEP=4.
module tb_control_ajustes;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_sel;
    logic [1:0] sel;
    logic [2:0] volt_div;
    logic [3:0] time_div;
    logic [7:0] trig_level;
    logic       cfg_stb;

    int n_tests = 0;
    int n_fail  = 0;
    int stb_cnt = 0;
    int base;

    control_ajustes #(
        .HOLD_CYCLES  (8),
        .REPEAT_CYCLES(4),
        .TRIG_STEP    (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_sel   (btn_sel),
        .sel       (sel),
        .volt_div  (volt_div),
        .time_div  (time_div),
        .trig_level(trig_level),
        .cfg_stb   (cfg_stb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk)
        if (cfg_stb === 1'b1)
            stb_cnt <= stb_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++)
            @(posedge clk);
        #1;
    endtask

    task automatic sel_pulse();
        btn_sel = 1'b1;
        cyc(1);
        btn_sel = 1'b0;
        cyc(2);
    endtask

    initial begin
        reset    = 1'b1;
        btn_up   = 1'b0;
        btn_down = 1'b0;
        btn_sel  = 1'b0;
        #2 reset = 1'b0;
        #1;
        chk("rst_sel", 32'(sel), 0);
        chk("rst_volt", 32'(volt_div), 3);
        chk("rst_time", 32'(time_div), 5);
        chk("rst_trig", 32'(trig_level), 128);
        chk("rst_stb", 32'(cfg_stb), 0);
        cyc(2);
        reset = 1'b1;
        cyc(2);
        chk("post_rst_volt", 32'(volt_div), 3);
        chk("post_rst_trig", 32'(trig_level), 128);

        // short press: one step, one strobe, no repeat
        base   = stb_cnt;
        btn_up = 1'b1;
        cyc(1);
        chk("t1_volt", 32'(volt_div), 4);
        chk("t1_stb_lo", 32'(cfg_stb), 0);
        cyc(1);
        chk("t1_stb_hi", 32'(cfg_stb), 1);
        cyc(1);
        chk("t1_stb_end", 32'(cfg_stb), 0);
        btn_up = 1'b0;
        cyc(20);
        chk("t1_no_rep", 32'(volt_div), 4);
        chk("t1_nstb", 32'(stb_cnt - base), 1);

        // sel cycling
        base = stb_cnt;
        sel_pulse();
        chk("sel_1", 32'(sel), 1);
        sel_pulse();
        chk("sel_2", 32'(sel), 2);
        sel_pulse();
        chk("sel_0", 32'(sel), 0);
        cyc(2);
        chk("sel_nstb", 32'(stb_cnt - base), 3);
        sel_pulse();
        sel_pulse();
        chk("sel_to2", 32'(sel), 2);

        // trigger hold + auto-repeat
        base   = stb_cnt;
        btn_up = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            cyc(1);
            chk("t3_trig", 32'(trig_level),
                128 + 4 * (1 + int'(i >= 10) + int'(i >= 14) + int'(i >= 18)));
        end
        btn_up = 1'b0;
        cyc(10);
        chk("t3_final", 32'(trig_level), 144);
        chk("t3_nstb", 32'(stb_cnt - base), 4);

        // saturate trigger high then low
        base   = stb_cnt;
        btn_up = 1'b1;
        cyc(150);
        btn_up = 1'b0;
        cyc(5);
        chk("trig_max", 32'(trig_level), 255);
        chk("trig_max_nstb", 32'(stb_cnt - base), 28);
        base     = stb_cnt;
        btn_down = 1'b1;
        cyc(300);
        btn_down = 1'b0;
        cyc(5);
        chk("trig_min", 32'(trig_level), 0);
        chk("trig_min_nstb", 32'(stb_cnt - base), 64);

        // time_div at upper bound
        sel_pulse();
        sel_pulse();
        chk("sel_time", 32'(sel), 1);
        btn_up = 1'b1;
        cyc(60);
        btn_up = 1'b0;
        cyc(5);
        chk("time_max", 32'(time_div), 11);
        base   = stb_cnt;
        btn_up = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        cyc(6);
        chk("time_sat", 32'(time_div), 11);
        chk("time_sat_nstb", 32'(stb_cnt - base), 0);
        base     = stb_cnt;
        btn_down = 1'b1;
        cyc(1);
        btn_down = 1'b0;
        chk("time_dn", 32'(time_div), 10);
        cyc(4);
        chk("time_dn_nstb", 32'(stb_cnt - base), 1);

        // volt_div to lower bound
        sel_pulse();
        sel_pulse();
        chk("sel_volt", 32'(sel), 0);
        btn_down = 1'b1;
        cyc(60);
        btn_down = 1'b0;
        cyc(3);
        chk("volt_min", 32'(volt_div), 0);

        // both buttons together: lock
        base     = stb_cnt;
        btn_up   = 1'b1;
        btn_down = 1'b1;
        cyc(20);
        chk("lock_both", 32'(volt_div), 0);
        btn_down = 1'b0;
        cyc(20);
        chk("lock_one", 32'(volt_div), 0);
        btn_up = 1'b0;
        cyc(3);
        chk("lock_nstb", 32'(stb_cnt - base), 0);
        btn_up = 1'b1;
        cyc(1);
        btn_up = 1'b0;
        chk("lock_exit", 32'(volt_div), 1);
        cyc(3);

        // opposite button during HOLD locks
        btn_up = 1'b1;
        cyc(5);
        chk("hold_step", 32'(volt_div), 2);
        btn_down = 1'b1;
        cyc(30);
        chk("hold_lock", 32'(volt_div), 2);
        btn_up   = 1'b0;
        btn_down = 1'b0;
        cyc(3);

        // sel edge during HOLD is discarded
        btn_up = 1'b1;
        cyc(4);
        btn_sel = 1'b1;
        cyc(1);
        btn_sel = 1'b0;
        chk("hold_sel", 32'(sel), 0);
        btn_up = 1'b0;
        cyc(3);
        chk("hold_sel_volt", 32'(volt_div), 3);
        chk("hold_sel_idle", 32'(sel), 0);

        // reset during REPEAT
        btn_down = 1'b1;
        cyc(15);
        chk("rep_volt", 32'(volt_div), 0);
        #1 reset = 1'b0;
        #1;
        chk("arst_volt", 32'(volt_div), 3);
        chk("arst_time", 32'(time_div), 5);
        chk("arst_trig", 32'(trig_level), 128);
        chk("arst_stb", 32'(cfg_stb), 0);
        cyc(2);
        reset = 1'b1;
        cyc(1);
        chk("rel_step", 32'(volt_div), 2);
        cyc(8);
        chk("rel_hold", 32'(volt_div), 2);
        cyc(1);
        chk("rel_rep", 32'(volt_div), 1);
        btn_down = 1'b0;
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
